layer0_input_packer: RTL
========================

Name: layer0_input_packer

Overview:
- Upstream neighbour of the layer-0 neuron LUTs.
- Accepts a stream of raw signed feature samples, one per beat, over a valid/ready handshake.
- Quantizes each sample to FEAT_W unsigned bits and packs one full sample vector into a flat input word.
- Presents that word on a registered valid/ready output. Layer-0 neurons slice their fan-in bits from this word.

Parameters:
- NUM_FEAT, 16, features per input vector; must be >= 2.
- SAMPLE_W, 8, width of the raw signed input sample.
- FEAT_W, 2, width of each quantized feature.
- SHIFT, 4, arithmetic right-shift applied before clamping.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active high.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat ready.
- s_data  input  SAMPLE_W  raw signed sample.
- s_last  input  1  marks the final feature of a vector.
- m_valid  output  1  packed vector valid.
- m_ready  input  1  downstream accepts the vector.
- m_data  output  NUM_FEAT*FEAT_W  packed vector; feature i occupies bits [i*FEAT_W +: FEAT_W].
- err_len  output  1  one-cycle pulse on a vector-length violation.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset state: idx=0, fill buffer=0, m_valid=0, m_data=0, err_len=0. s_ready reads 0 while rst is high.
- Quantization (combinational on s_data):
  - t = s_data >>> SHIFT, signed arithmetic shift.
  - q = 0 if t<0; q = 2^FEAT_W-1 if t>2^FEAT_W-1; otherwise q = t[FEAT_W-1:0].
- Accept: a beat is taken when s_valid && s_ready.
- Feature index:
  - idx counts 0..NUM_FEAT-1, width clog2(NUM_FEAT).
  - Each accepted beat writes q into fill-buffer slot idx.
- Non-final beat (idx<NUM_FEAT-1):
  - Without s_last: idx increments.
  - With s_last (early last): the partial vector is dropped, idx<=0, fill buffer cleared, err_len pulses the next cycle, nothing is emitted.
- Final beat (idx==NUM_FEAT-1):
  - m_data <= fill buffer with slot NUM_FEAT-1 replaced by the current q.
  - m_valid<=1, idx<=0, fill buffer cleared.
  - If s_last=0 (missing last), the vector is still emitted and err_len pulses the next cycle. The following beats start a new vector.
- Output register:
  - m_valid deasserts on the cycle after m_valid && m_ready, unless a new final beat is accepted in that same cycle; then m_valid stays 1 and m_data is replaced.
  - m_data and m_valid are stable while m_valid && !m_ready.
- Backpressure: s_ready = !rst && !(idx==NUM_FEAT-1 && m_valid && !m_ready).
  - Filling continues while an output is held; the stall applies only to the final beat.
- Latency: m_valid rises 1 cycle after the final beat is accepted.
- Throughput: 1 vector per NUM_FEAT cycles with m_ready tied high.
- Reset mid-vector or mid-hold: partial data and any held output are discarded, and the reset state is restored next cycle.
- err_len is a single-cycle pulse only. No sticky status is kept.
- Implementation is counter-driven, with all outputs registered except s_ready.

Test Plan:
(All scenarios use NUM_FEAT=4, SAMPLE_W=8, FEAT_W=2, SHIFT=4.)
- Basic packing: beats 0x25, 0x7F, 0x80, 0x10, last on the 4th, m_ready=1 -> one cycle later m_valid=1, m_data=8'h4E (slots 2,3,0,1), err_len=0.
- Clamp edges: samples 0x00, 0x0F, 0x30, 0xFF -> slots 0, 0, 3, 0, i.e. m_data=8'h30.
- Backpressure: m_ready=0 with a vector held while a second vector streams in -> the first 3 beats are accepted and s_ready=0 at the 4th. m_data holds the first vector. On m_ready=1, the 4th beat is accepted in the same cycle and the second vector appears on the next cycle with m_valid still 1.
- Early last: s_last on the 2nd beat -> err_len pulses once, no m_valid. The next 4 beats 0x10, 0x10, 0x10, 0x10 (last) -> m_data=8'h55.
- Missing last: 4 beats with s_last=0 -> vector emitted and err_len pulses. A following full vector packs normally.
- Reset mid-operation: rst high for 1 cycle after 2 beats -> m_valid=0, m_data=0. A subsequent 4-beat vector emits only the new data.

Source files
------------

// File: rtl/layer0_input_packer.sv
// Quantizes a stream of signed feature samples and packs each full vector
// into a flat word for the layer-0 neuron LUTs, behind a registered valid/ready.
module layer0_input_packer #(
    parameter int unsigned NUM_FEAT = 16,
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned FEAT_W   = 2,
    parameter int unsigned SHIFT    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [SAMPLE_W-1:0]          s_data,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_FEAT*FEAT_W-1:0]   m_data,
    output logic                         err_len
);

    localparam int unsigned IDX_W = $clog2(NUM_FEAT);
    localparam int unsigned LOW_W = (NUM_FEAT - 1) * FEAT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
    localparam logic signed [SAMPLE_W-1:0] QMAX = SAMPLE_W'((1 << FEAT_W) - 1);

    logic [IDX_W-1:0]           idx;
    // The top slot is never buffered: the final beat goes straight to m_data.
    logic [LOW_W-1:0]           fill;
    logic signed [SAMPLE_W-1:0] t;
    logic [FEAT_W-1:0]          q;
    logic                       at_last;
    logic                       take;

    assign t = $signed(s_data) >>> SHIFT;

    // Clamp the shifted sample into the unsigned feature range.
    always_comb begin
        q = '0;
        if (t[SAMPLE_W-1]) begin
            q = '0;
        end else if (t > QMAX) begin
            q = '1;
        end else begin
            q = t[FEAT_W-1:0];
        end
    end

    assign at_last = (idx == LAST_IDX);
    assign s_ready = !rst && !(at_last && m_valid && !m_ready);
    assign take    = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            fill    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            err_len <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (take) begin
                if (at_last) begin
                    m_data  <= {q, fill};
                    m_valid <= 1'b1;
                    idx     <= '0;
                    fill    <= '0;
                    err_len <= !s_last;
                end else if (s_last) begin
                    // Early last: drop the partial vector.
                    idx     <= '0;
                    fill    <= '0;
                    err_len <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                    for (int i = 0; i < int'(NUM_FEAT) - 1; i++) begin
                        if (idx == IDX_W'(i)) begin
                            fill[i*FEAT_W +: FEAT_W] <= q;
                        end
                    end
                end
            end
        end
    end

endmodule
